// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared states and constants for the PWM channel controller.
package pwm_ctrl_pkg;
  localparam int PWM_CNT_W = 8;
  localparam int NUM_CH = 16;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: shared PWM prescaler and 8-bit period counter.
// clear has priority over enable; wrap flags the edge that takes the counter 255->0.
module pwm_timebase import pwm_ctrl_pkg::*; #(
  parameter int PRESCALE = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  output logic [PWM_CNT_W-1:0] cnt,
  output logic                 wrap
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  logic [PW-1:0] pre_q, pre_d;
  logic [PWM_CNT_W-1:0] cnt_q, cnt_d;
  logic tick;
  // Kept outside the next-state block so wrap never depends on clear.
  assign tick = enable && pre_q == PRE_MAX;
  assign wrap = tick && cnt_q == '1;
  assign cnt = cnt_q;
  always_comb begin
    pre_d = clear ? '0 : enable ? (tick ? '0 : pre_q + 1'b1) : pre_q;
    cnt_d = clear ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/pwm_channel_controller.sv
// pwm_channel_controller: drives 16 PWM/static pins from SPI config via a shared timebase.
// Define PWM_SYNC_UPDATE_EN to defer running config updates to the period boundary.
module pwm_channel_controller import pwm_ctrl_pkg::*; #(
  parameter int PRESCALE = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [PWM_CNT_W-1:0] pwm_duty_cycle,
  input  logic                 cfg_update,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic                 period_start,
  output logic                 update_pending
);
  state_t state_q, state_d;
  logic [NUM_CH-1:0] en_out_q, en_out_d, en_pwm_q, en_pwm_d, pwm_out_q, pwm_out_d;
  logic [NUM_CH-1:0] en_out_in, en_pwm_in;
  logic [PWM_CNT_W-1:0] duty_q, duty_d, cnt;
  logic period_start_q, period_start_d;
  logic wrap, load, pwm, clear, enable;
  assign en_out_in = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm_in = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign enable = state_q != IDLE;
  assign clear = state_d == IDLE;
  pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .enable (enable),
    .cnt    (cnt),
    .wrap   (wrap)
  );
  always_comb begin
    load = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        load = cfg_update;
        state_d = cfg_update && |en_out_in ? RUN : IDLE;
      end
`ifdef PWM_SYNC_UPDATE_EN
      RUN: begin
        load = cfg_update && wrap;
        state_d = cfg_update && !wrap ? PEND : RUN;
      end
      PEND: begin
        load = wrap;
        state_d = !wrap ? PEND : |en_out_in ? RUN : IDLE;
      end
`else
      RUN: begin
        load = cfg_update;
        state_d = cfg_update && !(|en_out_in) ? IDLE : RUN;
      end
`endif
      default: state_d = IDLE;
    endcase
    en_out_d = load ? en_out_in : en_out_q;
    en_pwm_d = load ? en_pwm_in : en_pwm_q;
    duty_d = load ? pwm_duty_cycle : duty_q;
    pwm = cnt < duty_q || duty_q == DUTY_FULL;
    pwm_out_d = en_out_q & (~en_pwm_q | {NUM_CH{pwm}});
    period_start_d = wrap;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_out_q <= '0;
      en_pwm_q <= '0;
      duty_q <= '0;
      pwm_out_q <= '0;
      period_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_out_q <= en_out_d;
      en_pwm_q <= en_pwm_d;
      duty_q <= duty_d;
      pwm_out_q <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end
  assign pwm_out = pwm_out_q;
  assign period_start = period_start_q;
`ifdef PWM_SYNC_UPDATE_EN
  assign update_pending = state_q == PEND;
`else
  assign update_pending = 1'b0;
`endif
endmodule

// File: tb/tb_pwm_channel_controller.sv
// tb_pwm_channel_controller: scoreboard bench for pwm_channel_controller.
// Expected outputs come from a time-based model pushed at each edge and popped on the next falling edge.
module tb_pwm_channel_controller;
  import pwm_ctrl_pkg::*;
  localparam int P = 13;
  localparam int PER = 256 * P;
`ifdef PWM_SYNC_UPDATE_EN
  localparam logic EXP_UP = 1'b1;
  localparam logic EXP_B = 1'b0;
`else
  localparam logic EXP_UP = 1'b0;
  localparam logic EXP_B = 1'b1;
`endif
  logic clk = 1'b0, rst_n = 1'b0, cfg = 1'b0;
  logic [15:0] en_out = '0, en_pwm = '0, pwm_out;
  logic [7:0] duty = '0;
  logic period_start, update_pending;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic [15:0] o; logic ps; logic up;} exp_t;
  exp_t sb[$];
  int m_state = 0, m_t = 0;
  logic [15:0] m_out = '0, m_pwm = '0;
  logic [7:0] m_duty = '0;
  always #5 clk = ~clk;
  pwm_channel_controller #(.PRESCALE(P)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .cfg_update      (cfg),
    .pwm_out         (pwm_out),
    .period_start    (period_start),
    .update_pending  (update_pending)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Model time m_t counts clocks since the timebase left IDLE; the counter is derived from it.
  task automatic model_step();
    int c, nx;
    bit w, ld;
    exp_t e;
    c = (m_t / P) % 256;
    w = m_state != 0 && (m_t % PER) == PER - 1;
    e.o = m_out & (~m_pwm | {16{(c < m_duty) || m_duty == 8'hFF}});
    e.ps = w;
    ld = 0;
    nx = m_state;
    if (m_state == 0) begin
      ld = cfg;
      nx = (cfg && en_out != 0) ? 1 : 0;
    end else if (m_state == 1) begin
`ifdef PWM_SYNC_UPDATE_EN
      ld = cfg && w;
      nx = (cfg && !w) ? 2 : 1;
`else
      ld = cfg;
      nx = (cfg && en_out == 0) ? 0 : 1;
`endif
    end else begin
      ld = w;
      nx = !w ? 2 : (en_out != 0 ? 1 : 0);
    end
    if (ld) begin
      m_out = en_out;
      m_pwm = en_pwm;
      m_duty = duty;
    end
    m_t = (nx == 0 || m_state == 0) ? 0 : m_t + 1;
    m_state = nx;
    e.up = nx == 2;
    sb.push_back(e);
  endtask
  task automatic step();
    exp_t e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    e = sb.pop_front();
    chk("pwm_out", pwm_out, e.o);
    chk("period_start", period_start, e.ps);
    chk("update_pending", update_pending, e.up);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic cfg_write(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    en_out = eo;
    en_pwm = ep;
    duty = d;
    cfg = 1'b1;
    step();
    cfg = 1'b0;
  endtask
  task automatic wait_ps(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < PER + 20 && !ok; i++) begin
      step();
      ok = period_start;
    end
    chk({tag, "_wait"}, ok, 1);
  endtask
  task automatic measure(input string tag, input int exp_highs);
    int len, highs;
    wait_ps(tag);
    highs = pwm_out[0];
    for (len = 1; len <= PER + 20; len++) begin
      step();
      if (period_start) break;
      highs += pwm_out[0];
    end
    chk({tag, "_period"}, len, PER);
    chk({tag, "_highs"}, highs, exp_highs);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pwm_out", pwm_out, 0);
    chk("rst_period_start", period_start, 0);
    chk("rst_update_pending", update_pending, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      en_out = 16'($urandom);
      en_pwm = 16'($urandom);
      duty = 8'($urandom);
      step();
    end
    chk("idle_cnt", dut.cnt, 0);
    cfg_write(16'hFFFF, 16'h0000, 8'h00);
    chk("all_on_load_edge", pwm_out, 16'h0000);
    step();
    chk("all_on", pwm_out, 16'hFFFF);
    run(50);
    cfg_write(16'h0001, 16'h0001, 8'h80);
    wait_ps("d80_settle");
    measure("d80", 128 * P);
    measure("d80_again", 128 * P);
    cfg_write(16'h0001, 16'h0001, 8'h00);
    wait_ps("d00_settle");
    measure("d00", 0);
    cfg_write(16'h0001, 16'h0001, 8'hFF);
    wait_ps("dff_settle");
    measure("dff", PER);
    cfg_write(16'h0001, 16'h0001, 8'h40);
    wait_ps("d40_settle");
    wait_ps("d40_start");
    run(1000);
    chk("d40_low", pwm_out[0], 0);
    cfg_write(16'h0001, 16'h0001, 8'hC0);
    step();
    chk("pend_flag", update_pending, EXP_UP);
    chk("duty_switch", pwm_out[0], EXP_B);
    run(200);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pwm_out", pwm_out, 0);
    chk("async_rst_period_start", period_start, 0);
    chk("async_rst_update_pending", update_pending, 0);
    chk("async_rst_state", dut.state_q, IDLE);
    chk("async_rst_cnt", dut.cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_state = 0;
    m_t = 0;
    m_out = '0;
    m_pwm = '0;
    m_duty = '0;
    run(20);
    cfg_write(16'hFFFF, 16'h0000, 8'h00);
    step();
    chk("all_on_after_rst", pwm_out, 16'hFFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
